regfile_wb_queue: RTL

Write-back queue sitting between the execute/memory stages and the 32×32 register file write port. It accepts register writes from two producers (ALU and load unit) over valid/ready, buffers them in a small in-order FIFO, and drives the register file's single write port (write enable, write number, write data) at one write per cycle. It also gives the decode stage combinational forwarding for both read ports, so a register read never returns stale data while its write is still queued.

---
 rtl/citrus_rf_pkg.sv | 15 +
 rtl/wbq_fwd_match.sv | 48 ++++
 rtl/regfile_wb_queue.sv | 121 ++++++++++++
 3 files changed

// File: rtl/citrus_rf_pkg.sv
// citrus_rf_pkg
// Shared definitions for the register-file write-back path: default widths,
// default queue depth and the write-back entry record {wn, d}.
package citrus_rf_pkg;

    localparam int AW_DEF    = 5;
    localparam int DW_DEF    = 32;
    localparam int DEPTH_DEF = 4;

    typedef struct packed {
        logic [AW_DEF-1:0] wn;
        logic [DW_DEF-1:0] d;
    } wb_entry_t;

endpackage

// File: rtl/wbq_fwd_match.sv
// wbq_fwd_match
// Forwarding lookup for one decode read port. Scans the occupied queue slots
// from oldest to youngest; a later match overrides an earlier one, so the
// youngest pending write wins. Register 0 never hits. Purely combinational.
//
// Ports:
//   rn      read register number
//   rd_ptr  queue head slot (oldest entry)
//   count   number of occupied slots
//   wn, d   queue storage (register number / data per slot)
//   hit     a pending write for rn exists
//   data    youngest pending data for rn, 0 when no hit
module wbq_fwd_match
    import citrus_rf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic [AW-1:0]              rn,
    input  logic [$clog2(DEPTH)-1:0]   rd_ptr,
    input  logic [$clog2(DEPTH):0]     count,
    input  logic [AW-1:0]              wn [DEPTH],
    input  logic [DW-1:0]              d  [DEPTH],
    output logic                       hit,
    output logic [DW-1:0]              data
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] slot;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        slot = '0;
        for (int k = 0; k < DEPTH; k++) begin
            // age k counts from the head; slot index wraps with the pointer width
            slot = rd_ptr + PW'(k);
            if ((CW'(k) < count) && (wn[slot] == rn) && (rn != '0)) begin
                hit  = 1'b1;
                data = d[slot];
            end
        end
    end

endmodule

// File: rtl/regfile_wb_queue.sv
// regfile_wb_queue
// In-order write-back queue between the load unit / ALU and the single
// register-file write port, with combinational forwarding for two read ports.
//
// Ports:
//   clk, clr                       clock, async active-high reset
//   mem_valid/wn/d, mem_ready      load-unit write request (older instruction)
//   alu_valid/wn/d, alu_ready      ALU write request
//   rf_we, rf_wn, rf_d             register-file write port (head of queue)
//   ra, rb                         decode read numbers
//   fwd_a_hit/data, fwd_b_hit/data youngest pending write per read port
//   count, empty, full             occupancy
module regfile_wb_queue
    import citrus_rf_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_wn,
    input  logic [DW-1:0]            mem_d,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_wn,
    input  logic [DW-1:0]            alu_d,
    output logic                     alu_ready,
    output logic                     rf_we,
    output logic [AW-1:0]            rf_wn,
    output logic [DW-1:0]            rf_d,
    input  logic [AW-1:0]            ra,
    input  logic [AW-1:0]            rb,
    output logic                     fwd_a_hit,
    output logic [DW-1:0]            fwd_a_data,
    output logic                     fwd_b_hit,
    output logic [DW-1:0]            fwd_b_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] wn_q [DEPTH];
    logic [DW-1:0] d_q  [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    logic          mem_push, alu_push, pop;
    logic [PW-1:0] alu_slot;
    logic [1:0]    n_push;

    assign empty = (count == '0);
    assign full  = (count == DEPTH_C);

    // Readiness looks only at registered occupancy; the same-cycle pop is
    // deliberately ignored so there is no ready path through the drain.
    assign mem_ready = (count < DEPTH_C);
    assign alu_ready = (count < DEPTH_C - CW'(1)) || ((count < DEPTH_C) && !mem_valid);

    // r0 writes complete the handshake but are dropped.
    assign mem_push = mem_valid && mem_ready && (mem_wn != '0);
    assign alu_push = alu_valid && alu_ready && (alu_wn != '0);
    assign pop      = !empty;
    assign n_push   = {1'b0, mem_push} + {1'b0, alu_push};

    // Load is older, so it takes the first free slot and the ALU entry follows.
    assign alu_slot = wr_ptr + PW'(mem_push);

    assign rf_we = !empty;
    assign rf_wn = wn_q[rd_ptr];
    assign rf_d  = d_q[rd_ptr];

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PW'(n_push);
            rd_ptr <= rd_ptr + PW'(pop);
            count  <= count + CW'(n_push) - CW'(pop);
        end
    end

    // Slot contents need no reset: occupancy alone decides validity.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            wn_q[wr_ptr] <= mem_wn;
            d_q[wr_ptr]  <= mem_d;
        end
        if (alu_push) begin
            wn_q[alu_slot] <= alu_wn;
            d_q[alu_slot]  <= alu_d;
        end
    end

    wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_a (
        .rn     (ra),
        .rd_ptr (rd_ptr),
        .count  (count),
        .wn     (wn_q),
        .d      (d_q),
        .hit    (fwd_a_hit),
        .data   (fwd_a_data)
    );

    wbq_fwd_match #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fwd_b (
        .rn     (rb),
        .rd_ptr (rd_ptr),
        .count  (count),
        .wn     (wn_q),
        .d      (d_q),
        .hit    (fwd_b_hit),
        .data   (fwd_b_data)
    );

endmodule
